// File: rtl/itl_wr_ctrl_if.sv
// Interleaver loader bus: incoming soft-bit stream plus the RAM write port.
// The slave modport is the loader; the master modport is whatever feeds and observes it.
interface itl_wr_ctrl_if #(
  parameter int D_WIDTH = 2,
  parameter int A_WIDTH = 12
);
  logic [D_WIDTH-1:0] in_data;
  logic               in_vld;
  logic               in_rdy;
  logic [D_WIDTH-1:0] wdata;
  logic [A_WIDTH-1:0] waddr;
  logic [A_WIDTH-1:0] pb_offset;
  logic               wefn;
  logic               din_vld;

  modport master (
    output in_data, in_vld,
    input  in_rdy, wdata, waddr, pb_offset, wefn, din_vld
  );

  modport slave (
    input  in_data, in_vld,
    output in_rdy, wdata, waddr, pb_offset, wefn, din_vld
  );
endinterface

// File: rtl/itl_wr_ctrl.sv
// Interleaver write controller: loads one PB worth of soft-bit pairs into the
// interleaver RAM at contiguous addresses, then drains for the downstream read latency.
module itl_wr_ctrl #(
  parameter int D_WIDTH = 2,
  parameter int A_WIDTH = 12
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic [1:0]   pb_sel,
  itl_wr_ctrl_if.slave bus,
  output logic         busy,
  output logic         done,
  output logic         err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam logic [A_WIDTH-1:0] LAST_PB16  = A_WIDTH'(12'd63);
  localparam logic [A_WIDTH-1:0] LAST_PB136 = A_WIDTH'(12'd543);
  localparam logic [A_WIDTH-1:0] LAST_PB520 = A_WIDTH'(12'd2079);
  localparam logic [A_WIDTH-1:0] OFF_PB16   = A_WIDTH'(12'd0);
  localparam logic [A_WIDTH-1:0] OFF_PB136  = A_WIDTH'(12'd64);
  localparam logic [A_WIDTH-1:0] OFF_PB520  = A_WIDTH'(12'd608);

  state_e             state_q, state_d;
  logic [A_WIDTH-1:0] cnt_q, cnt_d;
  logic [A_WIDTH-1:0] last_q, last_d;
  logic [A_WIDTH-1:0] pb_offset_q, pb_offset_d;
  logic [D_WIDTH-1:0] wdata_q, wdata_d;
  logic [A_WIDTH-1:0] waddr_q, waddr_d;
  logic               wefn_q, wefn_d;
  logic               din_vld_q, din_vld_d;
  logic               in_rdy_q, in_rdy_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               drain_q, drain_d;
  logic               accept_s;

  // Next-state and registered-output computation.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    last_d      = last_q;
    pb_offset_d = pb_offset_q;
    wdata_d     = wdata_q;
    waddr_d     = waddr_q;
    wefn_d      = 1'b1;
    din_vld_d   = 1'b0;
    err_d       = 1'b0;
    drain_d     = drain_q;
    accept_s    = in_rdy_q & bus.in_vld;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (pb_sel == 2'd3) begin
            err_d = 1'b1;
          end else begin
            state_d = LOAD;
            cnt_d   = '0;
            case (pb_sel)
              2'd0: begin
                last_d      = LAST_PB16;
                pb_offset_d = OFF_PB16;
              end
              2'd1: begin
                last_d      = LAST_PB136;
                pb_offset_d = OFF_PB136;
              end
              default: begin
                last_d      = LAST_PB520;
                pb_offset_d = OFF_PB520;
              end
            endcase
          end
        end else begin
          state_d = IDLE;
        end
      end
      LOAD: begin
        if (accept_s) begin
          wdata_d   = bus.in_data;
          waddr_d   = cnt_q;
          wefn_d    = 1'b0;
          din_vld_d = 1'b1;
          // The counter parks on N-1 so nothing past the PB end can be addressed.
          if (cnt_q == last_q) begin
            state_d = DRAIN;
            drain_d = 1'b0;
          end else begin
            cnt_d = cnt_q + A_WIDTH'(1'b1);
          end
        end else begin
          state_d = LOAD;
        end
      end
      DRAIN: begin
        if (drain_q) begin
          state_d = DONE;
        end else begin
          drain_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_rdy_d = (state_d == LOAD);
    // done is registered off the DONE state, so busy is stretched to cover it.
    busy_d   = (state_d != IDLE) | (state_q == DONE);
    done_d   = (state_q == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      last_q      <= '0;
      pb_offset_q <= '0;
      wdata_q     <= '0;
      waddr_q     <= '0;
      wefn_q      <= 1'b1;
      din_vld_q   <= 1'b0;
      in_rdy_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      drain_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      pb_offset_q <= pb_offset_d;
      wdata_q     <= wdata_d;
      waddr_q     <= waddr_d;
      wefn_q      <= wefn_d;
      din_vld_q   <= din_vld_d;
      in_rdy_q    <= in_rdy_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      drain_q     <= drain_d;
    end
  end

  assign bus.in_rdy    = in_rdy_q;
  assign bus.wdata     = wdata_q;
  assign bus.waddr     = waddr_q;
  assign bus.pb_offset = pb_offset_q;
  assign bus.wefn      = wefn_q;
  assign bus.din_vld   = din_vld_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;

endmodule

// File: tb/tb_itl_wr_ctrl.sv
// Randomized bench for itl_wr_ctrl: feeds PBs with random gaps and compares the
// observed write stream against the expected pair list for each PB.
module tb_itl_wr_ctrl;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       start = 1'b0;
  logic [1:0] pb_sel = 2'd0;
  logic       busy, done, err;

  itl_wr_ctrl_if #(.D_WIDTH(2), .A_WIDTH(12)) bus ();

  itl_wr_ctrl #(.D_WIDTH(2), .A_WIDTH(12)) dut (
    .clk    (clk),
    .n_rst  (n_rst),
    .start  (start),
    .pb_sel (pb_sel),
    .bus    (bus),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int addr_q[$];
  int data_q[$];
  int off_q[$];
  int last_wr_cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int err_cnt = 0;
  int err_cyc = 0;
  int cur_off = 0;
  bit busy_fall_pending = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Passive monitor: records writes, done and err pulses; checks per-cycle invariants.
  always @(negedge clk) begin
    if (n_rst) begin
      chk("wefn_vs_din_vld", {31'd0, bus.wefn}, {31'd0, ~bus.din_vld});
      if (!busy) chk("in_rdy_when_idle", {31'd0, bus.in_rdy}, 32'd0);
      if (busy_fall_pending) begin
        chk("busy_after_done", {31'd0, busy}, 32'd0);
        busy_fall_pending = 1'b0;
      end
      if (bus.din_vld) begin
        addr_q.push_back(int'(bus.waddr));
        data_q.push_back(int'(bus.wdata));
        off_q.push_back(int'(bus.pb_offset));
        last_wr_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
        chk("busy_at_done", {31'd0, busy}, 32'd1);
        busy_fall_pending = 1'b1;
      end
      if (err) begin
        err_cnt++;
        err_cyc = cyc;
      end
    end
  end

  task automatic check_reset_vals(input string tag);
    chk({tag, "_in_rdy"},  {31'd0, bus.in_rdy},  32'd0);
    chk({tag, "_wdata"},   {30'd0, bus.wdata},   32'd0);
    chk({tag, "_waddr"},   {20'd0, bus.waddr},   32'd0);
    chk({tag, "_offset"},  {20'd0, bus.pb_offset}, 32'd0);
    chk({tag, "_wefn"},    {31'd0, bus.wefn},    32'd1);
    chk({tag, "_din_vld"}, {31'd0, bus.din_vld}, 32'd0);
    chk({tag, "_busy"},    {31'd0, busy},        32'd0);
    chk({tag, "_done"},    {31'd0, done},        32'd0);
    chk({tag, "_err"},     {31'd0, err},         32'd0);
  endtask

  // Loads one PB; optional restart injection, start on the last pair, or reset abort.
  task automatic run_pb(input int sel, input int pct, input int inject_at,
                        input bit start_at_last, input int abort_at);
    int n, off, idx, guard;
    int data[$];
    bit injected;
    n   = (sel == 0) ? 64 : (sel == 1) ? 544 : 2080;
    off = ((sel >= 1) ? 64 : 0) + ((sel >= 2) ? 544 : 0);
    data.delete();
    for (int i = 0; i < n; i++) data.push_back(int'($urandom_range(0, 3)));
    addr_q.delete(); data_q.delete(); off_q.delete();
    done_cnt = 0; err_cnt = 0; injected = 1'b0;

    @(posedge clk); #1;
    start = 1'b1; pb_sel = 2'(sel); bus.in_vld = 1'b0;
    @(negedge clk);
    idx = 0; guard = 0;
    while (idx < n && guard < 20000) begin
      @(posedge clk); #1;
      start  = 1'b0;
      pb_sel = 2'($urandom_range(0, 3));
      if (inject_at >= 0 && idx == inject_at && !injected) begin
        start = 1'b1; pb_sel = 2'd2; injected = 1'b1;
      end
      if (start_at_last && idx == n - 1) begin
        start = 1'b1; pb_sel = 2'd0;
      end
      bus.in_vld  = ($urandom_range(0, 99) < pct);
      bus.in_data = 2'(data[idx]);
      @(negedge clk);
      if (abort_at >= 0 && idx == abort_at) begin
        #2 n_rst = 1'b0;
        #1 check_reset_vals("abort");
        @(negedge clk);
        n_rst = 1'b1;
        start = 1'b0;
        cur_off = 0;
        addr_q.delete();
        bus.in_vld = 1'b1;
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          chk("post_abort_in_rdy", {31'd0, bus.in_rdy}, 32'd0);
          chk("post_abort_busy", {31'd0, busy}, 32'd0);
        end
        chk("post_abort_writes", addr_q.size(), 32'd0);
        bus.in_vld = 1'b0;
        return;
      end
      if (bus.in_vld && bus.in_rdy) idx++;
      guard++;
    end
    chk("load_timeout", idx, n);

    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      bus.in_vld  = 1'b1;
      bus.in_data = 2'($urandom_range(0, 3));
      @(negedge clk);
      chk("in_rdy_after_last", {31'd0, bus.in_rdy}, 32'd0);
    end
    bus.in_vld = 1'b0;
    cur_off = off;

    chk("n_writes", addr_q.size(), n);
    for (int i = 0; i < addr_q.size() && i < n; i++) begin
      chk("waddr", addr_q[i], i);
      chk("wdata", data_q[i], data[i]);
      chk("pb_offset", off_q[i], off);
    end
    chk("max_ram_addr", off + n - 1 <= 2687, 32'd1);
    chk("done_count", done_cnt, 32'd1);
    chk("done_latency", done_cyc - last_wr_cyc, 32'd3);
    chk("no_err", err_cnt, 32'd0);
  endtask

  task automatic run_illegal();
    int start_cyc;
    addr_q.delete(); err_cnt = 0; done_cnt = 0;
    @(posedge clk); #1;
    start = 1'b1; pb_sel = 2'd3; bus.in_vld = 1'b1;
    @(negedge clk);
    start_cyc = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("illegal_busy", {31'd0, busy}, 32'd0);
      chk("illegal_offset", {20'd0, bus.pb_offset}, cur_off);
    end
    bus.in_vld = 1'b0;
    chk("illegal_err_count", err_cnt, 32'd1);
    chk("illegal_err_latency", err_cyc - start_cyc, 32'd1);
    chk("illegal_writes", addr_q.size(), 32'd0);
    chk("illegal_done", done_cnt, 32'd0);
  endtask

  initial begin
    bus.in_vld  = 1'b0;
    bus.in_data = 2'd0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_vals("post_reset");

    run_pb(0, 100, -1, 1'b0, -1);
    run_pb(2, 60, -1, 1'b0, -1);
    run_illegal();
    run_pb(1, 80, 100, 1'b0, -1);
    run_pb(1, 75, -1, 1'b0, 100);
    run_pb(0, 70, -1, 1'b0, -1);
    run_pb(0, 100, -1, 1'b1, -1);
    run_pb(1, 50, -1, 1'b0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
